// File: rtl/alu_result_stage.sv
// Execute-stage result register: captures ALU outputs, detects signed add/sub overflow as a trap,
// and buffers results in a 2-entry skid. Optional counters are built when ALU_STAGE_STATS_EN is defined.
module alu_result_stage #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_result,
   input  logic          in_zero,
   input  logic          in_a_msb,
   input  logic          in_b_msb,
   input  logic [1:0]    in_ovf_chk,
   input  logic [RW-1:0] in_rd,
   input  logic          in_reg_write,
   input  logic [DW-1:0] in_pc,
   input  logic          flush,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_result,
   output logic          out_zero,
   output logic [RW-1:0] out_rd,
   output logic          out_reg_write,
   output logic          out_exc,
   output logic          ovf_sticky,
   output logic [DW-1:0] ovf_epc,
`ifdef ALU_STAGE_STATS_EN
   output logic [31:0]   stat_ops,
   output logic [31:0]   stat_ovf,
`endif
   input  logic          ovf_clr
);

   typedef struct packed {
      logic [DW-1:0] result;
      logic          zero;
      logic [RW-1:0] rd;
      logic          reg_write;
      logic          exc;
   } entry_t;

   // Overflow from sign bits only; the ALU's own carry-out is not meaningful for signed ops.
   function automatic logic ovf_calc(input logic [1:0] chk, input logic a, input logic b,
                                     input logic r);
      case (chk)
         2'b01:   return (a == b) && (r != a);
         2'b10:   return (a != b) && (r != a);
         default: return 1'b0;
      endcase
   endfunction

   logic   skid_valid;
   entry_t skid_q;
   entry_t in_entry_p0;
   logic   in_exc_p0;
   logic   accept_p0;
   logic   main_le;

   assign in_ready  = ~skid_valid;
   assign in_exc_p0 = ovf_calc(in_ovf_chk, in_a_msb, in_b_msb, in_result[DW-1]);
   assign accept_p0 = in_valid & in_ready & ~flush;
   assign main_le   = ~out_valid | out_ready;

   always_comb begin
      in_entry_p0.result    = in_result;
      in_entry_p0.zero      = in_zero;
      in_entry_p0.rd        = in_rd;
      in_entry_p0.reg_write = in_reg_write & ~in_exc_p0;
      in_entry_p0.exc       = in_exc_p0;
   end

   // Main/skid slots: skid is only occupied while main is also occupied.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid     <= 1'b0;
         skid_valid    <= 1'b0;
         skid_q        <= '0;
         out_result    <= '0;
         out_zero      <= 1'b0;
         out_rd        <= '0;
         out_reg_write <= 1'b0;
         out_exc       <= 1'b0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (skid_valid) begin
         if (out_ready) begin
            skid_valid    <= 1'b0;
            out_result    <= skid_q.result;
            out_zero      <= skid_q.zero;
            out_rd        <= skid_q.rd;
            out_reg_write <= skid_q.reg_write;
            out_exc       <= skid_q.exc;
         end
      end else if (accept_p0) begin
         if (main_le) begin
            out_valid     <= 1'b1;
            out_result    <= in_entry_p0.result;
            out_zero      <= in_entry_p0.zero;
            out_rd        <= in_entry_p0.rd;
            out_reg_write <= in_entry_p0.reg_write;
            out_exc       <= in_entry_p0.exc;
         end else begin
            skid_valid <= 1'b1;
            skid_q     <= in_entry_p0;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_sticky <= 1'b0;
         ovf_epc    <= '0;
      end else begin
         if (accept_p0 && in_exc_p0) ovf_sticky <= 1'b1;
         else if (ovf_clr)           ovf_sticky <= 1'b0;
         if (accept_p0 && in_exc_p0 && !ovf_sticky) ovf_epc <= in_pc;
      end
   end

`ifdef ALU_STAGE_STATS_EN
   // Clear wins over a same-cycle increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_ops <= '0;
         stat_ovf <= '0;
      end else if (ovf_clr) begin
         stat_ops <= '0;
         stat_ovf <= '0;
      end else if (accept_p0) begin
         stat_ops <= stat_ops + 32'd1;
         if (in_exc_p0) stat_ovf <= stat_ovf + 32'd1;
      end
   end
`endif

endmodule
